// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard frame receiver and scan-code decoder (E0/F0 prefixes, device responses dropped).
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_error
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TmoOne = CntW'(1);
  localparam logic [CntW-1:0] TmoMax = CntW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StData   = 2'd1;
  localparam logic [1:0] StParity = 2'd2;
  localparam logic [1:0] StStop   = 2'd3;

  logic [1:0]      clk_sync_q, data_sync_q;
  logic            clk_prev_q;
  logic [1:0]      state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0] tmo_q, tmo_d;
  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic [10:0]     key_q, key_d;
  logic            err_q, err_d;
`ifdef PS2_PARITY_CHECK_EN
  logic            parity_q, parity_d;
`endif

  logic ps2_clk_s, ps2_data_s, fall, frame_ok;

  assign ps2_clk_s  = clk_sync_q[1];
  assign ps2_data_s = data_sync_q[1];
  assign fall       = clk_prev_q & ~ps2_clk_s;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    key_d     = key_q;
    err_d     = 1'b0;
    frame_ok  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    parity_d  = parity_q;
`endif
    if (fall) begin
      tmo_d = '0;
      case (state_q)
        StIdle: begin
          if (!ps2_data_s) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end
        end
        StData: begin
          shift_d   = {ps2_data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
`ifdef PS2_PARITY_CHECK_EN
          parity_d = ps2_data_s;
`endif
          state_d = StStop;
        end
        default: begin
          state_d = StIdle;
`ifdef PS2_PARITY_CHECK_EN
          // Odd parity over data plus parity bit means an odd XOR reduction.
          frame_ok = ps2_data_s & (^{shift_q, parity_q});
`else
          frame_ok = ps2_data_s;
`endif
          if (!frame_ok) begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
          end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
          end else if (shift_q != 8'hFA && shift_q != 8'hAA &&
                       shift_q != 8'hEE && shift_q != 8'hFE) begin
            key_d = {~key_q[10], ~brk_q, ext_q, shift_q};
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
      endcase
    end else if (state_q != StIdle) begin
      if (tmo_q == TmoMax) begin
        state_d = StIdle;
        tmo_d   = '0;
        err_d   = 1'b1;
        ext_d   = 1'b0;
        brk_d   = 1'b0;
      end else begin
        tmo_d = tmo_q + TmoOne;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      state_q     <= StIdle;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      tmo_q       <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      key_q       <= 11'h000;
      err_q       <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      clk_prev_q  <= ps2_clk_s;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_q       <= tmo_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      key_q       <= key_d;
      err_q       <= err_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign ps2_key     = key_q;
  assign frame_error = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: the driver queues expected key/error events, the monitor
// pops and checks them (value and stop-edge latency) whenever the DUT publishes or flags an error.
module tb_ps2_key_decoder;

  localparam int unsigned TMO  = 200;
  localparam int          HALF = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_error;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_key     (ps2_key),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [10:0] key;
    int          due;
  } ev_t;

  ev_t         sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [10:0] prev_key = 11'h000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_event(input bit is_err, input logic [10:0] key);
    ev_t e;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL unexpected_event: got err=%0b key=%h, required no event", is_err, key);
      return;
    end
    e = sb.pop_front();
    if (e.is_err == is_err && (is_err || e.key == key)) n_pass++;
    else $display("FAIL event_value: got err=%0b key=%h, required err=%0b key=%h",
                  is_err, key, e.is_err, e.key);
    if (e.due >= 0) begin
      n_checks++;
      if (cyc == e.due + 3) n_pass++;
      else $display("FAIL event_latency: got cycle %0d, required cycle %0d", cyc, e.due + 3);
    end
  endtask

  // Monitor: sampled on the falling clk edge, away from DUT updates.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_key = 11'h000;
    end else begin
      if (frame_error) check_event(1'b1, 11'h000);
      if (ps2_key !== prev_key) begin
        check_event(1'b0, ps2_key);
        prev_key = ps2_key;
      end
    end
  end

  task automatic check_now(input string name, input logic [10:0] key_exp, input logic err_exp);
    n_checks++;
    if (ps2_key === key_exp && frame_error === err_exp) n_pass++;
    else $display("FAIL %s: got key=%h err=%0b, required key=%h err=%0b",
                  name, ps2_key, frame_error, key_exp, err_exp);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop,
                            input bit exp_any, input bit exp_err, input logic [10:0] exp_key);
    logic par;
    @(negedge clk);
    par = ~(^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    ps2_data = stop;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    if (exp_any) sb.push_back('{exp_err, exp_key, cyc});
    repeat (HALF) @(negedge clk);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_now("reset_state", 11'h000, 1'b0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 11'h61C);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000);
    check_now("after_f0", 11'h61C, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 11'h01C);
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000);
    check_now("after_e0", 11'h01C, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b1, 1'b0, 11'h775);
    send_frame(8'hFA, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000);
    check_now("after_fa", 11'h775, 1'b0);

`ifdef PS2_PARITY_CHECK_EN
    send_frame(8'h1C, 1'b1, 1'b1, 1'b1, 1'b1, 11'h000);
    check_now("bad_parity", 11'h775, 1'b0);
`else
    send_frame(8'h1C, 1'b1, 1'b1, 1'b1, 1'b0, 11'h21C);
`endif

    // E0 prefix must be forgotten after a bad stop bit.
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000);
    send_frame(8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 11'h000);

    @(negedge clk);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    sb.push_back('{1'b1, 11'h000, -1});
    repeat (TMO + 30) @(negedge clk);
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL timeout_error: got %0d pending events, required 0", sb.size());

`ifdef PS2_PARITY_CHECK_EN
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 11'h21C);
`else
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 11'h61C);
`endif

    @(negedge clk);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_now("mid_frame_reset", 11'h000, 1'b0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 11'h41C);

    repeat (50) @(negedge clk);
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending events, required 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion by %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 50000, max clk cycles between PS/2 clock falling edges inside a frame before it is aborted.
REQ-002 SHALL have port: clk  input  1  system clock; the single clock domain.
REQ-003 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-005 SHALL have port: ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-006 SHALL have port: ps2_key  output  11  key event bus: [10] toggle, [9] pressed, [8] extended, [7:0] scan code.
REQ-007 SHALL have port: frame_error  output  1  one-cycle pulse on an aborted or rejected frame.

Function
REQ-008 SHALL pass ps2_clk and ps2_data through two-flop synchronizers; all logic uses only the synchronized copies.
REQ-009 SHALL detect a falling edge as synchronized ps2_clk 1 in the previous cycle and 0 in the current cycle, and sample synchronized ps2_data on that cycle.
REQ-010 SHALL run frame FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing only on falling edges.
REQ-011 SHALL in IDLE treat sampled 0 as start bit (go DATA, bit count 0) and ignore sampled 1 (stay IDLE, no error).
REQ-012 SHALL in DATA shift 8 bits LSB first, then go PARITY; the parity bit is sampled in PARITY, then go STOP.
REQ-013 SHALL in STOP accept the byte if the stop bit is 1, else discard it, pulse frame_error, and go IDLE.
REQ-014 SHALL, in any non-IDLE state, count clk cycles since the last falling edge; on reaching TIMEOUT_CYCLES, abort to IDLE, pulse frame_error, and clear both prefix flags.
REQ-015 SHALL, for accepted byte E0, set the extended flag without publishing.
REQ-016 SHALL, for accepted byte F0, set the break flag without publishing.
REQ-017 SHALL drop accepted bytes FA, AA, EE and FE (device responses) without publishing, leaving the flags unchanged.
REQ-018 SHALL, for any other accepted byte, publish ps2_key = {~ps2_key[10], ~break, extended, byte} and clear both flags in the same cycle.
REQ-019 SHALL update ps2_key exactly one clk cycle after the stop-bit falling edge is detected; ps2_key holds its value between publications.
REQ-020 SHALL not change ps2_key on any discarded, rejected or aborted frame.
REQ-021 SHALL clear both flags on frame_error, so a byte following an error is never treated as prefixed.

Reset
REQ-022 SHALL, while reset_n=0, force: FSM IDLE, shift register 0, bit count 0, timeout counter 0, flags 0, ps2_key 11'h000, frame_error 0, synchronizers 1.
REQ-023 SHALL discard any partial frame on reset assertion mid-frame; the first frame after release starts from IDLE.

Configuration
REQ-024 SHALL, with PS2_PARITY_CHECK_EN defined, reject a frame whose 8 data bits plus parity bit contain an even number of ones: discard the byte, pulse frame_error in the STOP cycle, and clear the flags.
REQ-025 SHALL, without PS2_PARITY_CHECK_EN, sample and ignore the parity bit; no frame is rejected for parity.

Verification
REQ-026 SHALL test: after reset, frame 0x1C with valid parity and stop -> ps2_key=11'h61C one cycle after the stop edge; frame_error stays 0.
REQ-027 SHALL test: frames F0 then 1C -> no change after F0; after 1C, ps2_key=11'h01C.
REQ-028 SHALL test: frames E0 then 75 after the previous step -> ps2_key=11'h775; E0 alone leaves ps2_key unchanged.
REQ-029 SHALL test: frame 0x1C with wrong parity under PS2_PARITY_CHECK_EN -> one frame_error pulse, ps2_key unchanged; without the macro -> ps2_key toggles to the new event.
REQ-030 SHALL test: start bit plus 4 data bits then clock idle for TIMEOUT_CYCLES -> frame_error pulse, FSM IDLE, next full frame 0x1C decodes correctly.
REQ-031 SHALL test: reset_n low for 2 cycles mid-frame -> ps2_key=11'h000 and no frame_error; a following frame F0 then 1C gives ps2_key=11'h41C.
